// File: rtl/fix_to_fp_11_4_if.sv
// Stream interface for fix_to_fp_11_4: fixed-point words in, packed
// exception-tagged FP words out, each side with a valid/ready handshake.
interface fix_to_fp_11_4_if #(
  parameter int IN_W = 16,
  parameter int OW   = 18
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_data;
  logic            out_inexact;

  // producer/consumer side (drives inputs, takes results)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  // encoder side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );
endinterface

// File: rtl/fix_to_fp_11_4.sv
// fix_to_fp_11_4: 3-stage signed fixed-point to exception-tagged float
// encoder (wE=4, wF=11 by default).
// Stage 1: sign/magnitude + zero detect. Stage 2: leading-one search and
// left-normalize. Stage 3: round/truncate, range check, pack.
// Optional macro FX2FP_ROUND_EN selects round-to-nearest-even; without it
// the fraction is truncated toward zero and there is no carry path.
// The whole pipe advances together when the output is empty or taken.
module fix_to_fp_11_4 #(
  parameter int IN_W      = 16,
  parameter int FRAC_BITS = 7,
  parameter int WE        = 4,
  parameter int WF        = 11
) (
  input logic              clk,
  input logic              rst,
  fix_to_fp_11_4_if.slave  bus
);
  localparam int OW     = WE + WF + 3;
  localparam int STAGES = 3;
  localparam int PW     = $clog2(IN_W);
  localparam int EW     = PW + WE + 2;
  localparam int BIAS   = 2 ** (WE - 1) - 1;
  localparam int EMAX   = 2 ** WE - 1;
  // normalized magnitude padded below so guard/sticky exist even when
  // the input is narrower than the fraction
  localparam int XW     = IN_W + WF + 2;

  typedef struct packed {
    logic            sign;
    logic            zero;
    logic [IN_W-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic                  sign;
    logic                  zero;
    logic [IN_W-1:0]       norm;
    logic signed [EW-1:0]  exp;
  } s2_t;

  typedef struct packed {
    logic          inexact;
    logic [OW-1:0] word;
  } s3_t;

  logic [STAGES:1] vld_pipe;
  logic            advance;
  logic            accept;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  s3_t             s3_d, s3_q;

  assign advance      = ~vld_pipe[STAGES] | bus.out_ready;
  assign accept       = bus.in_valid & advance;
  assign bus.in_ready = advance;

  assign bus.out_valid   = vld_pipe[STAGES];
  assign bus.out_data    = s3_q.word;
  assign bus.out_inexact = s3_q.inexact;

  // valid bits shift as one unit; a stall freezes bubbles too
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], accept};
  end

  // stage 1: sign, magnitude (IN_W wide so the most negative value is exact), zero
  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.in_data[IN_W-1];
    s1_d.zero = (bus.in_data == '0);
    s1_d.mag  = s1_d.sign ? (~bus.in_data + IN_W'(1)) : bus.in_data;
  end

  // stage 2: find leading one, shift it to the MSB, derive unbiased exponent
  always_comb begin
    logic [PW-1:0] p;
    logic [PW-1:0] sh;
    p = '0;
    for (int i = 0; i < IN_W; i++)
      if (s1_q.mag[i]) p = PW'(i);
    sh        = PW'(IN_W - 1) - p;
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.zero = s1_q.zero;
    s2_d.norm = s1_q.mag << sh;
    s2_d.exp  = EW'(p) - EW'(FRAC_BITS);
  end

  // stage 3: fraction below the hidden one, rounding, range check, pack
  always_comb begin
    logic [XW-1:0] ext;
    logic [WF-1:0] frac;
    logic          guard;
    logic          sticky;
    int            eb;
`ifdef FX2FP_ROUND_EN
    logic          rnd_up;
    logic [WF:0]   sum;
`endif
    ext    = {s2_q.norm, {(WF + 2){1'b0}}};
    frac   = ext[XW-2 -: WF];
    guard  = ext[XW-2-WF];
    sticky = |ext[XW-3-WF:0];
    eb     = int'($signed(s2_q.exp)) + BIAS;
`ifdef FX2FP_ROUND_EN
    // nearest-even: round up on guard unless it is an exact tie on an even lsb
    rnd_up = guard & (sticky | frac[0]);
    sum    = {1'b0, frac} + {{WF{1'b0}}, rnd_up};
    frac   = sum[WF-1:0];
    // an all-ones fraction wraps to zero; the carry bumps the exponent
    if (sum[WF]) eb = eb + 1;
`endif
    s3_d = '0;
    if (s2_q.zero) begin
      s3_d = '0;
    end else if (eb > EMAX) begin
      s3_d.word    = {2'b10, s2_q.sign, {(WE + WF){1'b0}}};
      s3_d.inexact = 1'b1;
    end else if (eb < 0) begin
      s3_d.word    = '0;
      s3_d.inexact = 1'b1;
    end else begin
      s3_d.word    = {2'b01, s2_q.sign, eb[WE-1:0], frac};
      s3_d.inexact = guard | sticky;
    end
  end

  // stage data registers share the global advance with the valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (advance) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end
endmodule

// File: tb/tb_fix_to_fp_11_4.sv
// Directed bench for fix_to_fp_11_4: single-word latency/values,
// back-pressure ordering and hold, asynchronous reset mid-flight.
module tb_fix_to_fp_11_4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fix_to_fp_11_4_if bus ();
  fix_to_fp_11_4 dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_bad = 0;

`ifdef FX2FP_ROUND_EN
  localparam logic [17:0] W_7FFF = 18'h17800;
  localparam logic [17:0] W_1003 = 18'h16002;
`else
  localparam logic [17:0] W_7FFF = 18'h177FF;
  localparam logic [17:0] W_1003 = 18'h16001;
`endif

  typedef struct {
    logic [15:0] d;
    logic [17:0] w;
    logic        inx;
  } vec_t;

  vec_t vt[10];
  vec_t bp[6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one word with an idle pipe; checks latency, data, inexact
  task automatic send_one(input string tag, input vec_t v);
    int cyc;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = v.d;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 10) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd3);
    chk({tag, "_data"}, 32'(bus.out_data), 32'(v.w));
    chk({tag, "_inx"}, 32'(bus.out_inexact), 32'(v.inx));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int   sent;
    int   rcv;
    logic acc;
    logic hv;
    logic [17:0] held;

    vt[0] = '{16'h0080, 18'h13800, 1'b0};
    vt[1] = '{16'hFF80, 18'h1B800, 1'b0};
    vt[2] = '{16'h0000, 18'h00000, 1'b0};
    vt[3] = '{16'h8000, 18'h1F800, 1'b0};
    vt[4] = '{16'h7FFF, W_7FFF,    1'b1};
    vt[5] = '{16'h1001, 18'h16000, 1'b1};
    vt[6] = '{16'h1003, W_1003,    1'b1};
    vt[7] = '{16'h0001, 18'h10000, 1'b0};
    vt[8] = '{16'hFFFF, 18'h18000, 1'b0};
    vt[9] = '{16'h0155, 18'h142A8, 1'b0};

    bp[0] = vt[0]; bp[1] = vt[1]; bp[2] = vt[2];
    bp[3] = vt[3]; bp[4] = vt[9]; bp[5] = vt[7];

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_od", 32'(bus.out_data), 32'd0);
    chk("rst_inx", 32'(bus.out_inexact), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_rdy", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 10; i++) send_one($sformatf("v%0d", i), vt[i]);
    @(posedge clk);

    // back-pressure: stream 6 words, stall consumer for cycles 2..6
    sent = 0;
    rcv  = 0;
    hv   = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 2 && c < 7);
      bus.in_valid  = (sent < 6);
      if (sent < 6) bus.in_data = bp[sent].d;
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && !bus.out_ready) begin
        chk("bp_rdy", 32'(bus.in_ready), 32'd0);
        if (hv) chk("bp_hold", 32'(bus.out_data), 32'(held));
        held = bus.out_data;
        hv   = 1'b1;
      end else begin
        hv = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (rcv < 6) chk($sformatf("bp_ord%0d", rcv), 32'({bus.out_inexact, bus.out_data}),
                         32'({bp[rcv].inx, bp[rcv].w}));
        rcv++;
      end
      @(posedge clk);
      if (acc) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_sent", 32'(sent), 32'd6);
    chk("bp_rcv", 32'(rcv), 32'd6);
    repeat (3) begin
      @(posedge clk);
      #1 chk("bp_extra", 32'(bus.out_valid), 32'd0);
    end

    // reset with three words in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = vt[i].d;
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("pre_rst_ov", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_od", 32'(bus.out_data), 32'd0);
    chk("mid_rst_inx", 32'(bus.out_inexact), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 chk("rst_stale", 32'(bus.out_valid), 32'd0);
    end
    send_one("post_rst", vt[9]);
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/fix_to_fp_11_4.md
# fix_to_fp_11_4

Pipelined signed fixed-point to floating-point encoder for the ray/AABB datapath. It produces the 18-bit (wE=4, wF=11) exception-tagged operand words that the FP subtract and compare units consume. Fixed-point slab coordinates and ray origins enter on a valid/ready stream. Packed FP words leave on a second valid/ready stream with fixed 3-cycle latency, in order.

## Interface
- IN_W, 16, input word width (two's complement)
- FRAC_BITS, 7, fractional bits of input (default Q8.7)
- WE, 4, exponent width; bias = 2^(WE-1)-1 = 7
- WF, 11, fraction width; output width = WE+WF+3 = 18
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input word present
- in_ready  out  1  input accepted when in_valid & in_ready
- in_data  in  IN_W  signed fixed-point value
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer takes result when out_valid & out_ready
- out_data  out  WE+WF+3  packed float
- out_inexact  out  1  nonzero bits discarded by rounding/truncation (qualified by out_valid)

## Operation
- Output word layout:
  - [WE+WF+2:WE+WF+1] exn: 00 zero, 01 normal, 10 inf. 11 (NaN) is never produced.
  - [WE+WF] sign.
  - [WE+WF-1:WF] biased exponent.
  - [WF-1:0] fraction, hidden one not stored.
- Stage 1:
  - Register sign and magnitude = |in_data|. Magnitude is IN_W bits, so -2^(IN_W-1) is represented exactly.
  - Zero detect.
- Stage 2:
  - Leading-one position p (0..IN_W-1).
  - Left-normalize the magnitude so the leading one sits at the MSB.
  - Unbiased exponent e = p - FRAC_BITS.
- Stage 3:
  - Take the WF bits below the leading one.
  - Round per Configuration.
  - If the mantissa carries out of rounding: fraction = 0, e = e+1.
  - Pack the word.
- Zero input: exn=00, sign=0, exponent=0, fraction=0, inexact=0.
- e+bias > 2^WE-1 (after rounding): exn=10, exponent and fraction 0, sign kept, inexact=1.
- e+bias < 0: exn=00, all other bits 0, inexact=1. Not reachable with defaults.
- With default parameters every nonzero input is normal (exponent field 0..15).
- Magnitudes with p <= WF need no rounding. They are left-aligned with zero fill, and inexact=0.

## Timing
- Latency is exactly 3 clk edges from acceptance to out_valid, with no stall.
- Pipeline is globally enabled:
  - advance = ~out_valid | out_ready.
  - in_ready = advance, combinational.
  - On advance, all three stage registers and their valid bits shift together.
- Throughput is 1 word/cycle while out_ready=1.
- Bubbles are not compressed. A stalled pipeline holds all stages, including empty ones.
- out_data and out_inexact are stable while out_valid=1 and out_ready=0.
- in_data is sampled only on in_valid & in_ready.
- Results are delivered in acceptance order. None are dropped or duplicated.
- Reset values: all stage valid bits 0, out_valid=0, out_data=0, out_inexact=0. in_ready=1 while rst is deasserted.
- Reset mid-operation: all in-flight words are discarded immediately (asynchronous). The first cycle after release behaves as an empty pipeline.

## Configuration
- FX2FP_ROUND_EN defined:
  - Round to nearest, ties to even, using guard bit plus sticky OR of the remaining discarded bits.
  - Rounding may carry into the exponent and may produce inf.
- FX2FP_ROUND_EN undefined:
  - Truncate toward zero, with no rounding adder and no carry-to-exponent path.
  - inexact = OR of discarded bits.
- Latency, handshake and port list are identical in both builds.

## Test plan
- Defaults, single words, out_ready=1:
  - 0x0080 -> 0x13800 (+1.0)
  - 0xFF80 -> 0x1B800 (-1.0)
  - 0x0000 -> 0x00000
  - Each arrives exactly 3 cycles after acceptance, with inexact=0.
- 0x8000 (-256.0) -> 0x1F800, inexact=0 (extreme negative, exponent field 15).
- 0x7FFF:
  - With FX2FP_ROUND_EN: -> 0x17800, inexact=1 (rounding carries into the exponent).
  - Without: -> 0x177FF, inexact=1.
- Tie, 0x1001 with FX2FP_ROUND_EN: -> exponent field 12, fraction 0x000, inexact=1 (round to even stays down). 0x1003 -> fraction 0x002, inexact=1 (rounds up).
- Back-pressure:
  - Stream 6 words with in_valid=1, holding out_ready=0 from cycle 2 for 5 cycles.
  - Required: in_ready=0 while out_valid=1 and stalled.
  - Required: held out_data does not change.
  - Required: after release, all 6 results emerge in order with none lost.
- Assert rst for 1 cycle with 3 words in flight:
  - out_valid=0 and out_data=0 immediately.
  - No stale words emerge.
  - A word accepted after release appears 3 cycles later.
